// File: rtl/ocp_burst_reader.sv
// ---------------------------------------------------------------------------
// ocp_burst_reader
//
// OCP slave in front of a small register bank. Single-word WR commands are
// posted: they write the bank and produce no response. RD commands return
// MBurstLength consecutive words as DVA beats, one beat per accepted
// response. A zero-length or out-of-range RD returns a single ERR beat.
//
// Optional feature macro: OCP_RD_WRAP_EN
//   undefined (default): an RD with MAddr + MBurstLength > Depth gets ERR.
//   defined            : such an RD is legal and the read pointer wraps
//                        modulo Depth.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous, active-low reset
//   MCmd          in   3'b000 IDLE, 3'b001 WR, 3'b010 RD; others act as IDLE
//   MAddr         in   word address / burst start address
//   MBurstLength  in   RD beat count (ignored for WR)
//   MData         in   write data
//   SCmdAccept    out  command accepted this cycle (1 exactly in IDLE)
//   SResp         out  2'b00 NULL, 2'b01 DVA, 2'b11 ERR (registered)
//   SData         out  read data, valid while SResp = DVA (registered)
//   MRespAccept   in   master takes the current response beat
// ---------------------------------------------------------------------------
module ocp_burst_reader #(
    parameter int Width = 32,
    parameter int Depth = 8,
    parameter int AW    = 3,
    parameter int BLW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       MCmd,
    input  logic [AW-1:0]    MAddr,
    input  logic [BLW-1:0]   MBurstLength,
    input  logic [Width-1:0] MData,
    output logic             SCmdAccept,
    output logic [1:0]       SResp,
    output logic [Width-1:0] SData,
    input  logic             MRespAccept
);

    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [1:0] RESP_NUL = 2'b00;
    localparam logic [1:0] RESP_DVA = 2'b01;
    localparam logic [1:0] RESP_ERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RESP = 2'b01,
        S_ERR  = 2'b10
    } state_t;

    state_t             r_state;
    logic [AW-1:0]      r_ptr;
    logic [BLW-1:0]     r_cnt;
    logic [1:0]         r_sresp;
    logic [Width-1:0]   r_sdata;
    logic [Width-1:0]   r_bank [Depth];

    logic               w_cmd_wr;
    logic               w_cmd_rd;
    logic               w_rd_legal;
    logic [AW-1:0]      w_ptr_next;

    // Commands are only sampled in IDLE, which also freezes the bank while
    // a burst is being returned.
    assign SCmdAccept = (r_state == S_IDLE);
    assign w_cmd_wr   = SCmdAccept && (MCmd == CMD_WR);
    assign w_cmd_rd   = SCmdAccept && (MCmd == CMD_RD);

    // AW-bit increment: wraps modulo Depth for free since Depth = 2**AW.
    // Without wrap support a legal burst never increments past Depth-1.
    assign w_ptr_next = r_ptr + 1'b1;

`ifdef OCP_RD_WRAP_EN
    assign w_rd_legal = (MBurstLength != '0);
`else
    // End-address sum is widened so MAddr + MBurstLength cannot overflow.
    localparam int SW = (AW + 2 > BLW + 1) ? AW + 2 : BLW + 1;
    logic [SW-1:0] w_sum;
    assign w_sum      = SW'(MAddr) + SW'(MBurstLength);
    assign w_rd_legal = (MBurstLength != '0) && (w_sum <= SW'(Depth));
`endif

    assign SResp = r_sresp;
    assign SData = r_sdata;

    // Response FSM with registered SResp/SData.
    // NOTE: sequential state uses non-blocking (<=) so every register sees
    // the pre-edge values of the others, matching real flip-flop behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_sresp <= RESP_NUL;
            r_sdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_rd) begin
                        if (w_rd_legal) begin
                            r_state <= S_RESP;
                            r_ptr   <= MAddr;
                            r_cnt   <= MBurstLength;
                            r_sresp <= RESP_DVA;
                            r_sdata <= r_bank[MAddr];
                        end else begin
                            r_state <= S_ERR;
                            r_sresp <= RESP_ERR;
                            r_sdata <= '0;
                        end
                    end
                end
                S_RESP: begin
                    if (MRespAccept) begin
                        if (r_cnt > BLW'(1)) begin
                            r_ptr   <= w_ptr_next;
                            r_cnt   <= r_cnt - 1'b1;
                            r_sdata <= r_bank[w_ptr_next];
                        end else begin
                            r_state <= S_IDLE;
                            r_sresp <= RESP_NUL;
                            r_sdata <= '0;
                        end
                    end
                end
                S_ERR: begin
                    if (MRespAccept) begin
                        r_state <= S_IDLE;
                        r_sresp <= RESP_NUL;
                        r_sdata <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sresp <= RESP_NUL;
                    r_sdata <= '0;
                end
            endcase
        end
    end

    // Register bank with posted single-word writes.
    // NOTE: the bank is built from flops with an async clear because reset
    // must leave every word at zero; a RAM macro could not meet that.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_cmd_wr) begin
            r_bank[MAddr] <= MData;
        end
    end

endmodule
